// File: rtl/t05_huff_pkg.sv
// Purpose: shared types and constants for the Huffman min-pair scanner and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t05_huff_pkg;

    localparam int VAL_W_DEF  = 64;
    localparam int LEAF_N_DEF = 128;
    localparam int NODE_N_DEF = 128;
    localparam int ADDR_W_DEF = $clog2(LEAF_N_DEF + NODE_N_DEF);

    // Node ID: MSB set for internal (sum) nodes, low bits are the node index.
    typedef logic [ADDR_W_DEF:0] node_id_t;

    // All-ones marks an empty minimum slot; such a value can never win a strict compare.
    localparam node_id_t               SENT_ID  = '1;
    localparam logic [VAL_W_DEF-1:0]   SENT_VAL = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/t05_min2_update.sv
// Purpose: insert one (value, id) candidate into an ordered (min1, min2) pair.
// Latency: combinational.
// Backpressure: none.
// Ports: val_i/id_i candidate; min{1,2}_{val,id}_i current pair; min{1,2}_{val,id}_o updated pair.
// A zero value is an empty table slot and leaves the pair untouched. Compares are strict,
// so when candidates arrive in ascending address order the lower address wins ties.
module t05_min2_update #(
    parameter int VAL_W = 64,
    parameter int ID_W  = 9
) (
    input  logic [VAL_W-1:0] val_i,
    input  logic [ID_W-1:0]  id_i,
    input  logic [VAL_W-1:0] min1_val_i,
    input  logic [ID_W-1:0]  min1_id_i,
    input  logic [VAL_W-1:0] min2_val_i,
    input  logic [ID_W-1:0]  min2_id_i,
    output logic [VAL_W-1:0] min1_val_o,
    output logic [ID_W-1:0]  min1_id_o,
    output logic [VAL_W-1:0] min2_val_o,
    output logic [ID_W-1:0]  min2_id_o
);

    always_comb begin
        min1_val_o = min1_val_i;
        min1_id_o  = min1_id_i;
        min2_val_o = min2_val_i;
        min2_id_o  = min2_id_i;
        if (val_i != '0) begin
            if (val_i < min1_val_i) begin
                min2_val_o = min1_val_i;
                min2_id_o  = min1_id_i;
                min1_val_o = val_i;
                min1_id_o  = id_i;
            end else if (val_i < min2_val_i) begin
                min2_val_o = val_i;
                min2_id_o  = id_i;
            end
        end
    end

endmodule

// File: rtl/t05_min2_scanner.sv
// Purpose: scan the leaf + internal-node frequency table and return the two smallest non-zero entries.
// Latency: per read 1 (REQ) + SRAM latency + 1 (CMP); excluded address 1; done 1 cycle after last compare.
// Backpressure: rd_req/rd_addr held until rd_valid; start while busy is ignored.
// Ports: start/node_cnt kick a scan; rd_* is the SRAM read handshake; busy/done/found_cnt,
// min{1,2}_{id,val} and sum report the result, which holds until the next start.
module t05_min2_scanner
    import t05_huff_pkg::*;
#(
    parameter  int VAL_W    = VAL_W_DEF,
    parameter  int LEAF_N   = LEAF_N_DEF,
    parameter  int NODE_N   = NODE_N_DEF,
    parameter  bit EXCL_EN  = 1'b1,
    parameter  int EXCL_IDX = 26,
    localparam int ADDR_W   = $clog2(LEAF_N + NODE_N),
    localparam int CNT_W    = $clog2(NODE_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  node_cnt,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [VAL_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        found_cnt,
    output logic [ADDR_W:0]   min1_id,
    output logic [ADDR_W:0]   min2_id,
    output logic [VAL_W-1:0]  min1_val,
    output logic [VAL_W-1:0]  min2_val,
    output logic [VAL_W:0]    sum
);

    // Sentinels stretched from the package's all-ones constants to this instance's widths.
    localparam logic [ADDR_W:0]  SENT_ID_W  = {(ADDR_W + 1){SENT_ID[0]}};
    localparam logic [VAL_W-1:0] SENT_VAL_W = {VAL_W{SENT_VAL[0]}};
    // Address counter is one bit wider than rd_addr so a full table end (LEAF_N+NODE_N) fits.
    localparam logic [ADDR_W:0]  LEAF_END   = (ADDR_W + 1)'(LEAF_N);
    localparam logic [ADDR_W:0]  EXCL_ADDR  = (ADDR_W + 1)'(EXCL_IDX);
    localparam logic [CNT_W-1:0] NODE_MAX   = CNT_W'(NODE_N);

    state_t            state_q;
    logic [ADDR_W:0]   addr_q;
    logic [ADDR_W:0]   end_q;
    logic [VAL_W-1:0]  data_q;
    logic              rd_req_q;
    logic              done_q;
    logic [1:0]        found_q;
    logic [VAL_W:0]    sum_q;
    logic [VAL_W-1:0]  min1_val_q, min2_val_q;
    logic [ADDR_W:0]   min1_id_q, min2_id_q;

    logic [ADDR_W:0]   end_d;
    logic [ADDR_W:0]   cur_id;
    logic [VAL_W-1:0]  min1_val_d, min2_val_d;
    logic [ADDR_W:0]   min1_id_d, min2_id_d;
    logic              min1_vld, min2_vld;
    logic [1:0]        found_d;
    logic [VAL_W:0]    sum_d;

    always_comb begin
        end_d = LEAF_END + (ADDR_W + 1)'((node_cnt > NODE_MAX) ? NODE_MAX : node_cnt);
    end

    // Leaves keep their address; internal nodes are renumbered from zero with the MSB set.
    always_comb begin
        if (addr_q < LEAF_END) begin
            cur_id = {1'b0, addr_q[ADDR_W-1:0]};
        end else begin
            cur_id = {1'b1, ADDR_W'(addr_q - LEAF_END)};
        end
    end

    t05_min2_update #(
        .VAL_W (VAL_W),
        .ID_W  (ADDR_W + 1)
    ) u_update (
        .val_i      (data_q),
        .id_i       (cur_id),
        .min1_val_i (min1_val_q),
        .min1_id_i  (min1_id_q),
        .min2_val_i (min2_val_q),
        .min2_id_i  (min2_id_q),
        .min1_val_o (min1_val_d),
        .min1_id_o  (min1_id_d),
        .min2_val_o (min2_val_d),
        .min2_id_o  (min2_id_d)
    );

    // A slot is valid once it no longer holds the sentinel value; min2 valid implies min1 valid.
    always_comb begin
        min1_vld = (min1_val_q != SENT_VAL_W);
        min2_vld = (min2_val_q != SENT_VAL_W);
        found_d  = {1'b0, min1_vld} + {1'b0, min2_vld};
        sum_d    = '0;
        if (min1_vld) begin
            sum_d = {1'b0, min1_val_q};
        end
        if (min2_vld) begin
            sum_d = sum_d + {1'b0, min2_val_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            data_q     <= '0;
            rd_req_q   <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= '0;
            sum_q      <= '0;
            min1_val_q <= SENT_VAL_W;
            min2_val_q <= SENT_VAL_W;
            min1_id_q  <= SENT_ID_W;
            min2_id_q  <= SENT_ID_W;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        end_q      <= end_d;
                        addr_q     <= '0;
                        found_q    <= '0;
                        sum_q      <= '0;
                        min1_val_q <= SENT_VAL_W;
                        min2_val_q <= SENT_VAL_W;
                        min1_id_q  <= SENT_ID_W;
                        min2_id_q  <= SENT_ID_W;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (addr_q == end_q) begin
                        found_q <= found_d;
                        sum_q   <= sum_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (EXCL_EN && (addr_q == EXCL_ADDR)) begin
                        addr_q <= addr_q + 1'b1;
                    end else begin
                        rd_req_q <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_valid) begin
                        data_q   <= rd_data;
                        rd_req_q <= 1'b0;
                        state_q  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    min1_val_q <= min1_val_d;
                    min1_id_q  <= min1_id_d;
                    min2_val_q <= min2_val_d;
                    min2_id_q  <= min2_id_d;
                    addr_q     <= addr_q + 1'b1;
                    state_q    <= ST_REQ;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = addr_q[ADDR_W-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign found_cnt = found_q;
    assign sum       = sum_q;
    assign min1_val  = min1_val_q;
    assign min2_val  = min2_val_q;
    assign min1_id   = min1_id_q;
    assign min2_id   = min2_id_q;

endmodule

// File: tb/tb_t05_min2_scanner.sv
// Purpose: directed and randomised checks of the min-pair scanner against hand-computed results.
// Latency: n/a.
// Backpressure: SRAM model answers each request after a configurable or random latency.
module tb_t05_min2_scanner;
    import t05_huff_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  node_cnt;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic [1:0]  found_cnt;
    node_id_t    min1_id, min2_id;
    logic [63:0] min1_val, min2_val;
    logic [64:0] sum;

    t05_min2_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .node_cnt  (node_cnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .found_cnt (found_cnt),
        .min1_id   (min1_id),
        .min2_id   (min2_id),
        .min1_val  (min1_val),
        .min2_val  (min2_val),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [256];
    int          lat_fixed;
    int          n_chk, n_pass;
    int          reads, dones, bad_addr;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int          nc;
        int          a0, a1, a2, a3;
        logic [63:0] v0, v1, v2, v3;
        int          lat;
        int          found;
        logic [8:0]  id1, id2;
        logic [63:0] val1, val2;
        logic [64:0] sm;
        int          nreads;
    } vec_t;

    vec_t tbl [7];

    // SRAM model: one response per observed request, after lat_fixed (or random 1..5) cycles.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_req) begin
                int l;
                l = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
                repeat (l) @(posedge clk);
                #1;
                if (rd_req) begin
                    rd_valid = 1'b1;
                    rd_data  = mem[rd_addr];
                    @(posedge clk);
                    #1;
                    rd_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd_req && rd_valid) reads++;
        if (done) dones++;
        if (rd_req && rd_addr == 8'd26) bad_addr++;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Start one scan and wait (bounded) for done; optionally pulse start while busy.
    task automatic run_scan(input int nc, input bit poke, input string nm);
        int cyc;
        reads = 0; dones = 0; bad_addr = 0;
        @(posedge clk); #1;
        node_cnt = 8'(nc);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            if (done) break;
            start = poke && ($urandom_range(0, 6) == 0);
            cyc++;
        end
        start = 1'b0;
        check({nm, " done seen"}, {127'd0, done}, 128'd1);
        @(posedge clk); #1;
        check({nm, " done one cycle"}, {127'd0, done}, 128'd0);
        check({nm, " idle after"}, {127'd0, busy}, 128'd0);
    endtask

    function automatic vec_t mk(input int nc, input int a0, input logic [63:0] v0,
                                input int a1, input logic [63:0] v1, input int a2, input logic [63:0] v2,
                                input int a3, input logic [63:0] v3, input int lat, input int found,
                                input logic [8:0] id1, input logic [63:0] val1,
                                input logic [8:0] id2, input logic [63:0] val2,
                                input logic [64:0] sm, input int nreads);
        vec_t v;
        v.nc = nc; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.v0 = v0; v.v1 = v1; v.v2 = v2; v.v3 = v3;
        v.lat = lat; v.found = found; v.id1 = id1; v.id2 = id2;
        v.val1 = val1; v.val2 = val2; v.sm = sm; v.nreads = nreads;
        return v;
    endfunction

    task automatic load_vec(input vec_t v);
        clear_mem();
        if (v.a0 >= 0) mem[v.a0] = v.v0;
        if (v.a1 >= 0) mem[v.a1] = v.v1;
        if (v.a2 >= 0) mem[v.a2] = v.v2;
        if (v.a3 >= 0) mem[v.a3] = v.v3;
    endtask

    task automatic check_result(input string nm, input int found, input logic [8:0] id1,
                                input logic [63:0] val1, input logic [8:0] id2,
                                input logic [63:0] val2, input logic [64:0] sm, input int nreads);
        check({nm, " found_cnt"}, 128'(found_cnt), 128'(found));
        check({nm, " min1_id"},   128'(min1_id),   128'(id1));
        check({nm, " min1_val"},  128'(min1_val),  128'(val1));
        check({nm, " min2_id"},   128'(min2_id),   128'(id2));
        check({nm, " min2_val"},  128'(min2_val),  128'(val2));
        check({nm, " sum"},       128'(sum),       128'(sm));
        check({nm, " reads"},     128'(reads),     128'(nreads));
        check({nm, " done count"}, 128'(dones),    128'd1);
        check({nm, " addr 26 read"}, 128'(bad_addr), 128'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reads = 0; dones = 0; bad_addr = 0;
        lat_fixed = 1;
        start = 1'b0; node_cnt = '0;
        clear_mem();

        tbl[0] = mk(0, 0, 5, 1, 3, 3, 3, 4, 9, 1, 2, 9'd1, 3, 9'd3, 3, 65'd6, 127);
        tbl[1] = mk(3, 10, 7, 130, 4, 40, 4, -1, 0, 2, 2, 9'd40, 4, 9'h102, 4, 65'd8, 130);
        tbl[2] = mk(0, 26, 1, 50, 2, 60, 5, -1, 0, 3, 2, 9'd50, 2, 9'd60, 5, 65'd7, 127);
        tbl[3] = mk(0, 12, 8, -1, 0, -1, 0, -1, 0, 1, 1, 9'd12, 8, 9'h1FF, ONES, 65'd8, 127);
        tbl[4] = mk(0, -1, 0, -1, 0, -1, 0, -1, 0, 1, 0, 9'h1FF, ONES, 9'h1FF, ONES, 65'd0, 127);
        tbl[5] = mk(255, 255, 64'h10, 3, 64'hFFFF_FFFF_FFFF_FFFE, 128, 64'h10, -1, 0, 1, 2,
                    9'h100, 64'h10, 9'h17F, 64'h10, 65'h20, 255);
        tbl[6] = mk(0, 7, 64'hFFFF_FFFF_FFFF_FFFE, 8, 64'hFFFF_FFFF_FFFF_FFFD, -1, 0, -1, 0, 4, 2,
                    9'd8, 64'hFFFF_FFFF_FFFF_FFFD, 9'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                    65'h1_FFFF_FFFF_FFFF_FFFB, 127);

        rst = 1'b1;
        #23;
        check("reset rd_req",    128'(rd_req),    128'd0);
        check("reset rd_addr",   128'(rd_addr),   128'd0);
        check("reset busy",      128'(busy),      128'd0);
        check("reset done",      128'(done),      128'd0);
        check("reset found_cnt", 128'(found_cnt), 128'd0);
        check("reset min1_id",   128'(min1_id),   128'h1FF);
        check("reset min2_id",   128'(min2_id),   128'h1FF);
        check("reset min1_val",  128'(min1_val),  128'(ONES));
        check("reset min2_val",  128'(min2_val),  128'(ONES));
        check("reset sum",       128'(sum),       128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            load_vec(tbl[i]);
            lat_fixed = tbl[i].lat;
            run_scan(tbl[i].nc, 1'b0, nm);
            check_result(nm, tbl[i].found, tbl[i].id1, tbl[i].val1, tbl[i].id2,
                         tbl[i].val2, tbl[i].sm, tbl[i].nreads);
        end

        // Random latency with start pulses while busy, against an independent two-pass model.
        lat_fixed = 0;
        for (int r = 0; r < 3; r++) begin
            int nc, endv, b1, b2;
            logic [63:0] e1, e2;
            logic [8:0]  i1, i2;
            logic [64:0] es;
            int ef;
            clear_mem();
            nc   = int'($urandom_range(0, 10));
            endv = 128 + nc;
            for (int k = 0; k < 6; k++) mem[$urandom_range(0, endv - 1)] = 64'($urandom_range(1, 12));
            b1 = -1; b2 = -1;
            for (int a = 0; a < endv; a++)
                if (a != 26 && mem[a] != 0 && (b1 < 0 || mem[a] < mem[b1])) b1 = a;
            for (int a = 0; a < endv; a++)
                if (a != 26 && a != b1 && mem[a] != 0 && (b2 < 0 || mem[a] < mem[b2])) b2 = a;
            e1 = (b1 < 0) ? ONES : mem[b1];
            e2 = (b2 < 0) ? ONES : mem[b2];
            i1 = (b1 < 0) ? 9'h1FF : (b1 < 128 ? 9'(b1) : 9'(256 + b1 - 128));
            i2 = (b2 < 0) ? 9'h1FF : (b2 < 128 ? 9'(b2) : 9'(256 + b2 - 128));
            ef = (b1 >= 0 ? 1 : 0) + (b2 >= 0 ? 1 : 0);
            es = (b1 >= 0 ? {1'b0, e1} : 65'd0) + (b2 >= 0 ? {1'b0, e2} : 65'd0);
            run_scan(nc, 1'b1, $sformatf("rand%0d", r));
            check_result($sformatf("rand%0d", r), ef, i1, e1, i2, e2, es, endv - 1);
        end

        // Reset while waiting on a slow read: rd_req drops at once, no done, next scan is clean.
        begin
            int cyc;
            load_vec(tbl[0]);
            lat_fixed = 30;
            dones = 0;
            @(posedge clk); #1;
            node_cnt = 8'd0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 0;
            while (!rd_req && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("rst-wait rd_req seen", 128'(rd_req), 128'd1);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst-wait rd_req dropped", 128'(rd_req), 128'd0);
            check("rst-wait busy dropped",   128'(busy),   128'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (40) @(posedge clk);
            check("rst-wait no done", 128'(dones), 128'd0);
            lat_fixed = 1;
            run_scan(0, 1'b0, "post-rst");
            check_result("post-rst", 2, 9'd1, 3, 9'd3, 3, 65'd6, 127);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
